regfile_sb_v3: RTL

//  Parametrised multi-port register file with write-back bypass and a per-register busy scoreboard.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_sb_v3_scoreboard.sv | 73 +++++++
 rtl/regfile_sb_v3.sv | 81 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file types and defaults for the decoder, ALU and register file.
// Latency: none (declarations only).
// Backpressure: not applicable.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;

  // True for the architectural zero register.
  function automatic logic is_zero_reg(input reg_addr_t addr);
    return (addr == '0);
  endfunction

endpackage

// File: rtl/regfile_sb_v3_scoreboard.sv
// Busy scoreboard: one reservation bit per register, in-flight counter, orphan write-back flag.
// Latency: issue_ready is combinational; busy/count/orphan update on the next clock edge.
// Backpressure: issue_ready drops while the destination is busy, unless this cycle's write-back frees it.
// Ports: clk, reset_n; issue_valid/issue_rd in, issue_ready/issue_fire out;
//        wb_valid/wb_addr in; busy_vec, inflight_cnt, wb_orphan out.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS),
  localparam int CW      = $clog2(NREGS + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rd,
  output logic              issue_ready,
  output logic              issue_fire,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_addr,
  output logic [NREGS-1:0]  busy_vec,
  output logic [CW-1:0]     inflight_cnt,
  output logic              wb_orphan
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             orphan_q, orphan_d;

  logic issue_zero, wb_zero, set_en, clr_en, inc, dec;

  assign issue_zero = (ZERO_REG != 0) && (issue_rd == '0);
  assign wb_zero    = (ZERO_REG != 0) && (wb_addr == '0);

  // A same-cycle write-back to the requested register frees it in time.
  assign issue_ready = issue_zero || !busy_q[issue_rd] || (wb_valid && (wb_addr == issue_rd));
  assign issue_fire  = issue_valid && issue_ready;

  assign set_en = issue_fire && !issue_zero;
  assign clr_en = wb_valid && !wb_zero;

  // Count deltas track actual bit transitions so the counter always equals popcount.
  // When set and clear hit the same register the set wins and the bit stays 1.
  assign inc = set_en && !busy_q[issue_rd];
  assign dec = clr_en && busy_q[wb_addr] && !(set_en && (issue_rd == wb_addr));

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[wb_addr]  = 1'b0;
    if (set_en) busy_d[issue_rd] = 1'b1;
  end

  assign cnt_d    = cnt_q + {{(CW-1){1'b0}}, inc} - {{(CW-1){1'b0}}, dec};
  assign orphan_d = clr_en && !busy_q[wb_addr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q   <= '0;
      cnt_q    <= '0;
      orphan_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      orphan_q <= orphan_d;
    end
  end

  assign busy_vec     = busy_q;
  assign inflight_cnt = cnt_q;
  assign wb_orphan    = orphan_q;

endmodule

// File: rtl/regfile_sb_v3.sv
// Multi-port register file with write-back bypass and per-register busy scoreboard.
// Latency: reads are combinational (zero cycles); writes and reservations land on the next edge.
// Backpressure: issue_ready gates reservations; read ports flag hazards via rd_busy instead of stalling.
// Ports: clk, reset_n; rd_addr/rd_data/rd_busy (NRD packed ports); issue_valid/issue_rd/issue_ready;
//        wb_valid/wb_addr/wb_data; busy_vec, inflight_cnt, wb_orphan status.
module regfile_sb_v3
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS),
  localparam int CW      = $clog2(NREGS + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  output logic                issue_ready,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  output logic [NREGS-1:0]    busy_vec,
  output logic [CW-1:0]       inflight_cnt,
  output logic                wb_orphan
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic            issue_fire;
  logic            wb_zero;

  assign wb_zero = (ZERO_REG != 0) && (wb_addr == '0);

  rf_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk          (clk),
    .reset_n      (reset_n),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_ready  (issue_ready),
    .issue_fire   (issue_fire),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .busy_vec     (busy_vec),
    .inflight_cnt (inflight_cnt),
    .wb_orphan    (wb_orphan)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++) mem_q[r] <= '0;
    end else if (wb_valid && !wb_zero) begin
      mem_q[wb_addr] <= wb_data;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] addr;
    logic          addr_zero, wb_hit, fwd, reissue;

    assign addr      = rd_addr[g*AW +: AW];
    assign addr_zero = (ZERO_REG != 0) && (addr == '0);
    assign wb_hit    = wb_valid && (wb_addr == addr);
    assign fwd       = (BYPASS != 0) && wb_hit && !wb_zero;
    // A new producer reserving the register in the same cycle keeps the hazard alive
    // even though the old value is being forwarded.
    assign reissue   = issue_fire && (issue_rd == addr);

    assign rd_data[g*XLEN +: XLEN] = addr_zero ? '0 : (fwd ? wb_data : mem_q[addr]);
    assign rd_busy[g] = !addr_zero && busy_vec[addr]
                        && !((BYPASS != 0) && wb_hit && !reissue);
  end

endmodule
